dbus_sram_responder: RTL and testbench
======================================

Name: dbus_sram_responder

Overview:
- Data-bus responder: the target end of the dbus_req_t/dbus_resp_t protocol that the CPU core drives as initiator.
- Models a word-organised on-chip SRAM with programmable response latency and byte-strobe writes.
- Used as the simulation/FPGA backing store behind the core's data port, and as a latency-stress target for the core's stall logic.

Parameters:
- ADDR_WIDTH, 12, word-index bits; memory depth is 2**ADDR_WIDTH 32-bit words.
- LATENCY, 1, cycles from the accept edge to the data_ok cycle; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  asynchronous, active-low reset.
- dreq  input  72  dbus_req_t: valid[1], addr[32], size[3], strobe[4], data[32].
- dresp  output  34  dbus_resp_t: addr_ok[1], data_ok[1], data[32].

Behaviour:
- Reset (resetn low, asynchronous): state IDLE, counter 0, addr_ok=0, data_ok=0, data=0. Memory contents are not cleared. A transaction in flight when reset asserts is abandoned: no write commits and no data_ok is issued.
- States: IDLE, WAIT, RESP.
- IDLE:
  - addr_ok = dreq.valid (combinational).
  - On a clock edge with dreq.valid=1, latch addr, strobe and data; load counter = LATENCY-1.
  - Next state is RESP if LATENCY==1, otherwise WAIT.
- WAIT:
  - addr_ok=0.
  - Counter decrements each cycle; at count 1, next state is RESP.
- RESP:
  - data_ok=1 for exactly one cycle.
  - Read (latched strobe==0): data is the full memory word; the initiator extracts bytes.
  - Write (strobe!=0): byte lanes i with strobe[i]=1 are updated at the end of this cycle; data=0.
  - Next state is IDLE. addr_ok=0 in RESP, so back-to-back accept is impossible.
  - Maximum throughput is one access per LATENCY+1 cycles.
- Word index is addr[ADDR_WIDTH+1:2]. Upper address bits are ignored (aliasing). addr[1:0] and size are ignored except under the optional feature.
- The initiator holds dreq stable until addr_ok. Changes to dreq after the accept edge have no effect.
- data_ok and data are registered outputs. addr_ok is the only combinational output.
- Read-after-write to the same word across transactions returns the new value. Overlap within one transaction is impossible.

Optional Feature:
- Macro: DBUS_RESP_ALIGN_CHECK_EN.
- When defined, the check is applied at accept:
  - size=MSIZE2 with addr[0]!=0 is misaligned.
  - size=MSIZE4 with addr[1:0]!=0 is misaligned.
  - A misaligned write is dropped (no lanes change).
  - A misaligned read returns data=32'hdead_beef.
  - In both cases the same timing is kept and data_ok is still issued.
  - A sticky internal misalign flag is set; it is cleared only by reset and is visible via hierarchical reference for the bench.
- When undefined, there is no check, no flag, and addr[1:0]/size are fully ignored.

Decomposition:
- Shared package holds:
  - the state enum (IDLE/WAIT/RESP),
  - the constant MAX_LATENCY=15,
  - the constant MISALIGN_DATA=32'hdead_beef,
  - a function computing the word index.
- dbus_req_t, dbus_resp_t and MSIZE* come from the existing common definitions.
- One sub-module: word_ram. It is a single-port 2**ADDR_WIDTH x 32 array with 4-bit byte write-enable and registered read. The FSM instantiates it and owns all handshake timing.

Test Plan:
- Reset: hold resetn=0 with dreq.valid=1 -> addr_ok=0, data_ok=0, data=0. Deassert resetn -> addr_ok=1 combinationally in the same cycle.
- LATENCY=1 write then read:
  - Write addr=0x10, strobe=4'b1111, data=0x12345678 -> data_ok one cycle after accept, data=0.
  - Read addr=0x10 -> data_ok one cycle after accept, data=0x12345678.
- Partial strobe: write addr=0x10, strobe=4'b0011, data=0xAAAABBBB, then read -> 0x1234BBBB.
- LATENCY=3 timing:
  - Read accepted at cycle N -> data_ok only at N+3, addr_ok=0 at N+1..N+3.
  - Second request held valid is accepted at N+4.
- Alias and reset mid-op:
  - ADDR_WIDTH=12, read addr=0x4010 -> 0x1234BBBB.
  - LATENCY=3 write to 0x20, data 0x55, with resetn pulsed low at accept+1 -> no data_ok; a subsequent read of 0x20 returns the prior value.
- With DBUS_RESP_ALIGN_CHECK_EN:
  - Write size=MSIZE4 at addr=0x12 -> memory unchanged, flag=1.
  - Read at addr=0x12 -> data=32'hdead_beef.
  - Without the macro, the same read returns the word at index 4.

Source files
------------

// File: rtl/dbus_common_pkg.sv
// Common data-bus protocol definitions shared by the CPU core (initiator) and its targets.
package dbus_common_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

endpackage

// File: rtl/dbus_sram_responder_pkg.sv
// Shared types and constants for the dbus SRAM responder.
package dbus_sram_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int          MAX_LATENCY   = 15;
  localparam int          CNT_W         = $clog2(MAX_LATENCY + 1);
  localparam logic [31:0] MISALIGN_DATA = 32'hdead_beef;

  // Word index of a byte address; bits above the memory depth alias away.
  function automatic logic [29:0] word_index(input logic [31:0] addr, input int addr_width);
    logic [29:0] mask;
    mask = (30'd1 << addr_width) - 30'd1;
    return addr[31:2] & mask;
  endfunction

endpackage

// File: rtl/dbus_sram_responder_word_ram.sv
// Single-port 2**ADDR_WIDTH x 32 RAM, byte write-enables, registered read (read-first).
module dbus_sram_responder_word_ram #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [3:0]            we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] q_reg;

      always_ff @(posedge clk) begin
        if (en) begin
          if (we[gi]) mem[addr] <= wdata[8*gi +: 8];
          q_reg <= mem[addr];
        end
      end

      assign rdata[8*gi +: 8] = q_reg;
    end
  endgenerate

endmodule

// File: rtl/dbus_sram_responder.sv
// dbus target modelling an on-chip SRAM with programmable response latency (1..15).
// Optional alignment checking is enabled with `define DBUS_RESP_ALIGN_CHECK_EN.
module dbus_sram_responder
  import dbus_common_pkg::*;
  import dbus_sram_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [71:0] dreq,
  output logic [33:0] dresp
);

  dbus_req_t  req;
  dbus_resp_t resp;

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [ADDR_WIDTH-1:0]   idx_reg;
  logic [3:0]              strobe_reg;
  logic [31:0]             wdata_reg;

  logic                    accept;
  logic                    miss;
  logic                    ram_en;
  logic [3:0]              ram_we;
  logic [ADDR_WIDTH-1:0]   ram_addr;
  logic [31:0]             ram_q;
  logic                    unused_bits;

  assign req   = dbus_req_t'(dreq);
  assign dresp = resp;

  // Reset gates addr_ok so a request held during reset is not acknowledged.
  assign accept = resetn && (state_reg == IDLE) && req.valid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      idx_reg    <= '0;
      strobe_reg <= '0;
      wdata_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        idx_reg    <= ADDR_WIDTH'(word_index(req.addr, ADDR_WIDTH));
        strobe_reg <= req.strobe;
        wdata_reg  <= req.data;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (req.valid) begin
          cnt_next   = CNT_W'(LATENCY - 1);
          state_next = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == CNT_W'(1)) state_next = RESP;
      end
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    resp         = '0;
    resp.addr_ok = accept;
    if (state_reg == RESP) begin
      resp.data_ok = 1'b1;
      if (strobe_reg == 4'b0000) resp.data = miss ? MISALIGN_DATA : ram_q;
    end
  end

  // Reads are issued on the accept edge and the RAM holds its output until RESP;
  // writes commit on the edge that closes the RESP cycle.
  always_comb begin
    ram_en   = accept || ((state_reg == RESP) && (strobe_reg != 4'b0000));
    ram_we   = ((state_reg == RESP) && !miss) ? strobe_reg : 4'b0000;
    ram_addr = (state_reg == IDLE) ? ADDR_WIDTH'(word_index(req.addr, ADDR_WIDTH)) : idx_reg;
  end

  dbus_sram_responder_word_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_word_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(wdata_reg),
    .rdata(ram_q)
  );

`ifdef DBUS_RESP_ALIGN_CHECK_EN
  logic misalign_now;
  logic miss_reg;
  logic misalign_flag_reg;

  always_comb begin
    misalign_now = ((req.size == MSIZE2) && req.addr[0]) ||
                   ((req.size == MSIZE4) && (req.addr[1:0] != 2'b00));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      miss_reg          <= 1'b0;
      misalign_flag_reg <= 1'b0;
    end else if (accept) begin
      miss_reg <= misalign_now;
      if (misalign_now) misalign_flag_reg <= 1'b1;
    end
  end

  assign miss        = miss_reg;
  assign unused_bits = misalign_flag_reg;
`else
  assign miss        = 1'b0;
  assign unused_bits = ^{req.size, req.addr[1:0]};
`endif

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Bench for dbus_sram_responder: LATENCY=1 and LATENCY=3 instances against a transaction-level model.
module tb_dbus_sram_responder;
  import dbus_common_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic [71:0] dreq0 = '0, dreq1 = '0;
  logic [33:0] dresp0, dresp1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dbus_sram_responder #(.ADDR_WIDTH(12), .LATENCY(1)) dut1 (
    .clk(clk), .resetn(resetn), .dreq(dreq0), .dresp(dresp0));
  dbus_sram_responder #(.ADDR_WIDTH(12), .LATENCY(3)) dut3 (
    .clk(clk), .resetn(resetn), .dreq(dreq1), .dresp(dresp1));

  // Transaction-level model: per instance, busy flag, cycles left to data_ok, pending op, memory image.
  int          lat_of [2] = '{1, 3};
  bit          m_busy [2];
  int          m_left [2];
  logic [11:0] m_idx  [2];
  logic [3:0]  m_strb [2];
  logic [31:0] m_wd   [2];
  logic [31:0] m_rv   [2];
  bit          m_rvk  [2];
  bit          m_drop [2];
  logic [31:0] mem_m  [2][4096];
  bit          known_m[2][4096];

  function automatic logic [71:0] mk(input logic v, input logic [31:0] a, input logic [2:0] sz,
                                     input logic [3:0] st, input logic [31:0] wd);
    return {v, a, sz, st, wd};
  endfunction

  function automatic logic [33:0] get_resp(input int d);
    return (d == 0) ? dresp0 : dresp1;
  endfunction

  function automatic logic [71:0] get_req(input int d);
    return (d == 0) ? dreq0 : dreq1;
  endfunction

  task automatic set_req(input int d, input logic [71:0] v);
    if (d == 0) dreq0 = v;
    else dreq1 = v;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      logic [71:0] rq;
      logic [33:0] rs;
      logic [31:0] ea, eo, ed, a;
      bit          dk, mis;
      rq = get_req(d);
      rs = get_resp(d);
      ea = 0; eo = 0; ed = 0; dk = 1;
      if (!resetn) m_busy[d] = 0;
      else if (m_busy[d] && m_left[d] == 0) begin
        eo = 1; ed = m_rv[d]; dk = m_rvk[d];
      end else if (!m_busy[d]) ea = {31'd0, rq[71]};
      chk($sformatf("addr_ok[lat%0d]", lat_of[d]), {31'd0, rs[33]}, ea);
      chk($sformatf("data_ok[lat%0d]", lat_of[d]), {31'd0, rs[32]}, eo);
      if (dk) chk($sformatf("data[lat%0d]", lat_of[d]), rs[31:0], ed);
      if (resetn) begin
        if (m_busy[d] && m_left[d] == 0) begin
          if (m_strb[d] != 0 && !m_drop[d]) begin
            for (int i = 0; i < 4; i++)
              if (m_strb[d][i]) mem_m[d][m_idx[d]][8*i +: 8] = m_wd[d][8*i +: 8];
            if (m_strb[d] == 4'hF) known_m[d][m_idx[d]] = 1;
          end
          m_busy[d] = 0;
        end else if (m_busy[d]) begin
          m_left[d]--;
        end else if (rq[71]) begin
          a   = rq[70:39];
          mis = 0;
`ifdef DBUS_RESP_ALIGN_CHECK_EN
          mis = ((rq[38:36] == MSIZE2) && a[0]) || ((rq[38:36] == MSIZE4) && (a[1:0] != 0));
`endif
          m_idx[d]  = a[13:2];
          m_strb[d] = rq[35:32];
          m_wd[d]   = rq[31:0];
          m_drop[d] = mis;
          if (rq[35:32] == 0) begin
            m_rv[d]  = mis ? 32'hdead_beef : mem_m[d][a[13:2]];
            m_rvk[d] = mis || known_m[d][a[13:2]];
          end else begin
            m_rv[d]  = 0;
            m_rvk[d] = 1;
          end
          m_left[d] = lat_of[d] - 1;
          m_busy[d] = 1;
        end
      end
    end
  endtask

  task automatic wait_accept(input int d);
    int k;
    logic [33:0] rs;
    k = 0;
    @(negedge clk);
    rs = get_resp(d);
    while (!rs[33] && k < 50) begin
      @(negedge clk);
      rs = get_resp(d);
      k++;
    end
    if (k >= 50) chk("accept_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_dok(input int d, output logic [31:0] rd, output int lat);
    logic [33:0] rs;
    rd  = 'x;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      rs = get_resp(d);
      if (rs[32]) begin
        rd  = rs[31:0];
        lat = c;
        break;
      end
    end
    if (lat == 0) chk("data_ok_timeout", 32'd1, 32'd0);
  endtask

  task automatic txn(input int d, input logic [31:0] a, input logic [3:0] st, input logic [31:0] wd,
                     output logic [31:0] rd, output int lat);
    @(posedge clk); #1;
    set_req(d, mk(1'b1, a, MSIZE4, st, wd));
    wait_accept(d);
    @(posedge clk); #1;
    set_req(d, '0);
    wait_dok(d, rd, lat);
  endtask

  task automatic stimulus();
    logic [31:0] rd;
    logic [33:0] rs;
    int lat, cnt, acc_c, dok_c;

    // Reset held with a request pending.
    set_req(0, mk(1'b1, 32'h30, MSIZE4, 4'hF, 32'h0));
    set_req(1, mk(1'b1, 32'h30, MSIZE4, 4'hF, 32'h0));
    #1 resetn = 1'b0;
    repeat (3) @(negedge clk);
    rs = get_resp(0);
    chk("rst_addr_ok", {31'd0, rs[33]}, 32'd0);
    chk("rst_data_ok", {31'd0, rs[32]}, 32'd0);
    chk("rst_data", rs[31:0], 32'd0);
    @(posedge clk); #1 resetn = 1'b1;
    @(negedge clk);
    rs = get_resp(0);
    chk("rst_release_addr_ok", {31'd0, rs[33]}, 32'd1);
    @(posedge clk); #1;
    set_req(0, '0);
    set_req(1, '0);
    repeat (6) @(negedge clk);

    for (int d = 0; d < 2; d++) begin
      txn(d, 32'h10, 4'hF, 32'h1234_5678, rd, lat);
      chk($sformatf("wr_full_data[lat%0d]", lat_of[d]), rd, 32'h0);
      chk($sformatf("wr_full_lat[lat%0d]", lat_of[d]), lat, lat_of[d]);
      txn(d, 32'h10, 4'h0, 32'h0, rd, lat);
      chk($sformatf("rd_full_data[lat%0d]", lat_of[d]), rd, 32'h1234_5678);
      chk($sformatf("rd_full_lat[lat%0d]", lat_of[d]), lat, lat_of[d]);
      txn(d, 32'h10, 4'b0011, 32'hAAAA_BBBB, rd, lat);
      chk($sformatf("wr_part_data[lat%0d]", lat_of[d]), rd, 32'h0);
      txn(d, 32'h10, 4'h0, 32'h0, rd, lat);
      chk($sformatf("rd_part_data[lat%0d]", lat_of[d]), rd, 32'h1234_BBBB);
      txn(d, 32'h20, 4'hF, 32'h0BAD_F00D, rd, lat);
      chk($sformatf("wr_20_data[lat%0d]", lat_of[d]), rd, 32'h0);
    end

    txn(0, 32'h4010, 4'h0, 32'h0, rd, lat);
    chk("alias_rd_lat1", rd, 32'h1234_BBBB);

    // Back-to-back on LATENCY=3: second request held valid right after the first accept.
    @(posedge clk); #1;
    set_req(1, mk(1'b1, 32'h10, MSIZE4, 4'h0, 32'h0));
    wait_accept(1);
    @(posedge clk); #1;
    set_req(1, mk(1'b1, 32'h4010, MSIZE4, 4'h0, 32'h0));
    acc_c = -1;
    dok_c = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      rs = get_resp(1);
      if (rs[32]) begin
        dok_c = c;
        chk("b2b_first_data", rs[31:0], 32'h1234_BBBB);
      end
      if (rs[33]) begin
        acc_c = c;
        break;
      end
    end
    chk("b2b_data_ok_cycle", dok_c, 32'd3);
    chk("b2b_accept_cycle", acc_c, 32'd4);
    @(posedge clk); #1;
    set_req(1, '0);
    wait_dok(1, rd, lat);
    chk("alias_rd_lat3", rd, 32'h1234_BBBB);
    chk("alias_rd_lat3_lat", lat, 32'd3);

    // Reset pulsed one cycle after accepting a LATENCY=3 write.
    @(posedge clk); #1;
    set_req(1, mk(1'b1, 32'h20, MSIZE4, 4'hF, 32'h55));
    wait_accept(1);
    @(posedge clk); #1;
    set_req(1, '0);
    resetn = 1'b0;
    @(negedge clk);
    rs = get_resp(1);
    chk("rst_mid_data_ok", {31'd0, rs[32]}, 32'd0);
    @(posedge clk); #1 resetn = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      rs = get_resp(1);
      if (rs[32]) cnt++;
    end
    chk("rst_mid_no_data_ok", cnt, 32'd0);
    txn(1, 32'h20, 4'h0, 32'h0, rd, lat);
    chk("rst_mid_prior_value", rd, 32'h0BAD_F00D);

    // Misaligned word access at 0x12.
    txn(0, 32'h12, 4'hF, 32'hFFFF_FFFF, rd, lat);
    chk("mis_wr_data", rd, 32'h0);
    chk("mis_wr_lat", lat, 32'd1);
    txn(0, 32'h12, 4'h0, 32'h0, rd, lat);
`ifdef DBUS_RESP_ALIGN_CHECK_EN
    chk("mis_rd_data", rd, 32'hdead_beef);
    chk("mis_flag", {31'd0, dut1.misalign_flag_reg}, 32'd1);
    txn(0, 32'h10, 4'h0, 32'h0, rd, lat);
    chk("mis_mem_unchanged", rd, 32'h1234_BBBB);
`else
    chk("mis_rd_data", rd, 32'hFFFF_FFFF);
    txn(0, 32'h10, 4'h0, 32'h0, rd, lat);
    chk("mis_idx4_word", rd, 32'hFFFF_FFFF);
`endif

    repeat (4) @(negedge clk);
  endtask

  initial begin
    fork
      begin
        forever begin
          @(negedge clk);
          model_step();
        end
      end
      begin
        stimulus();
      end
    join_any
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
